// File: rtl/airlock_ctrl_if.sv
// airlock_ctrl_if
//   Groups the airlock controller's operator/timer inputs and its registered
//   actuator/status outputs.
//   Inputs to the controller : evac_req, press_req, inner_sw, outer_sw, cd_done
//   Outputs of the controller: countdown, inner_open, outer_open, pump_on,
//                              fault, state_o[2:0]
//   modport slave  : the controller side (consumes requests, drives actuators)
//   modport master : the environment side (drives requests, observes actuators)
//
// Signalling: all requests and switches are levels sampled on the rising
// clock edge; cd_done and countdown are single-cycle pulses with no
// acknowledge -- a pulse is seen exactly once, on the edge where it is high.
interface airlock_ctrl_if;
    logic       evac_req;
    logic       press_req;
    logic       inner_sw;
    logic       outer_sw;
    logic       cd_done;
    logic       countdown;
    logic       inner_open;
    logic       outer_open;
    logic       pump_on;
    logic       fault;
    logic [2:0] state_o;

    modport slave (
        input  evac_req, press_req, inner_sw, outer_sw, cd_done,
        output countdown, inner_open, outer_open, pump_on, fault, state_o
    );

    modport master (
        output evac_req, press_req, inner_sw, outer_sw, cd_done,
        input  countdown, inner_open, outer_open, pump_on, fault, state_o
    );
endinterface

// File: rtl/airlock_ctrl.sv
// airlock_ctrl
//   Chamber controller for a two-door airlock. Sequences evacuate (DRAIN) and
//   pressurize (FILL) cycles, fires a one-cycle start pulse into the external
//   countdown timer, waits for its cd_done, and traps a missing cd_done as a
//   sticky fault. The inner door may only open while pressurized (PRESS) and
//   the outer door only while evacuated (VAC), so both can never be open.
//
// Ports
//   Clock  : system clock, rising edge
//   Reset  : asynchronous active-low reset
//   bus    : airlock_ctrl_if.slave (requests/switches in, actuators/status out)
//
// Parameters
//   TIMEOUT : cycles allowed for cd_done after a countdown pulse (2..255)
//   CW      : watchdog width, 2**CW > TIMEOUT
module airlock_ctrl #(
    parameter int TIMEOUT = 32,
    parameter int CW      = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    airlock_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_PRESS = 3'd0,
        S_DRAIN = 3'd1,
        S_VAC   = 3'd2,
        S_FILL  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WD_MAX  = '1;

    state_t          state_q, state_d;
    logic            cd_q, cd_d;
    logic            inner_q, inner_d;
    logic            outer_q, outer_d;
    logic            pump_q, pump_d;
    logic            fault_q, fault_d;
    logic [CW-1:0]   wd_q, wd_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_PRESS;
            cd_q    <= 1'b0;
            inner_q <= 1'b0;
            outer_q <= 1'b0;
            pump_q  <= 1'b0;
            fault_q <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            inner_q <= inner_d;
            outer_q <= outer_d;
            pump_q  <= pump_d;
            fault_q <= fault_d;
            wd_q    <= wd_d;
        end
    end

    // Doors default closed and countdown defaults low, so a pulse can only
    // come from an accepted request and never lasts two cycles.
    always_comb begin
        state_d = state_q;
        cd_d    = 1'b0;
        inner_d = 1'b0;
        outer_d = 1'b0;
        pump_d  = 1'b0;
        fault_d = fault_q;
        wd_d    = wd_q;

        case (state_q)
            S_PRESS: begin
                inner_d = bus.inner_sw;
                // Both the request and the registered actuator must be low:
                // a door that is still physically open blocks evacuation.
                if (bus.evac_req && !bus.inner_sw && !inner_q) begin
                    state_d = S_DRAIN;
                    cd_d    = 1'b1;
                    pump_d  = 1'b1;
                    wd_d    = '0;
                end
            end

            S_VAC: begin
                outer_d = bus.outer_sw;
                if (bus.press_req && !bus.outer_sw && !outer_q) begin
                    state_d = S_FILL;
                    cd_d    = 1'b1;
                    pump_d  = 1'b1;
                    wd_d    = '0;
                end
            end

            S_DRAIN, S_FILL: begin
                if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
                // cd_done takes priority over an expiring watchdog.
                if (bus.cd_done) begin
                    state_d = (state_q == S_DRAIN) ? S_VAC : S_PRESS;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    pump_d = 1'b1;
                end
            end

            S_FAULT: begin
                fault_d = 1'b1;
            end

            default: begin
                // Unreachable encodings are treated as a fault.
                state_d = S_FAULT;
                fault_d = 1'b1;
            end
        endcase
    end

    assign bus.state_o    = state_q;
    assign bus.countdown  = cd_q;
    assign bus.inner_open = inner_q;
    assign bus.outer_open = outer_q;
    assign bus.pump_on    = pump_q;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_airlock_ctrl.sv
module tb_airlock_ctrl;

    localparam int TIMEOUT = 32;
    localparam int W       = 8;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    airlock_ctrl_if bus();

    airlock_ctrl #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];
    logic prev_cd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Chamber mode: 0 pressurized, 1 draining, 2 vacuum, 3 filling, 4 fault.
    // Timing tracked as cycles elapsed since the countdown pulse.
    int   m_mode;
    int   m_elapsed;
    logic m_cd, m_inner, m_outer, m_pump, m_fault;

    task automatic model_reset();
        m_mode = 0; m_elapsed = 0;
        m_cd = 0; m_inner = 0; m_outer = 0; m_pump = 0; m_fault = 0;
    endtask

    task automatic model_step();
        logic old_inner, old_outer;
        old_inner = m_inner;
        old_outer = m_outer;
        m_cd = 0; m_inner = 0; m_outer = 0; m_pump = 0;
        if (!Reset) begin
            model_reset();
        end else if (m_mode == 0 || m_mode == 2) begin
            logic req, sw, door;
            req  = (m_mode == 0) ? bus.evac_req : bus.press_req;
            sw   = (m_mode == 0) ? bus.inner_sw : bus.outer_sw;
            door = (m_mode == 0) ? old_inner : old_outer;
            if (req && !sw && !door) begin
                m_mode    = m_mode + 1;
                m_cd      = 1;
                m_pump    = 1;
                m_elapsed = 0;
            end else if (m_mode == 0) begin
                m_inner = sw;
            end else begin
                m_outer = sw;
            end
        end else if (m_mode == 1 || m_mode == 3) begin
            m_elapsed++;
            if (bus.cd_done)                m_mode = (m_mode + 1) % 4;
            else if (m_elapsed == TIMEOUT) begin m_mode = 4; m_fault = 1; end
            else                            m_pump = 1;
        end else begin
            m_fault = 1;
        end
    endtask

    function automatic logic [W-1:0] model_vec();
        return {3'(m_mode), m_cd, m_inner, m_outer, m_pump, m_fault};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {bus.state_o, bus.countdown, bus.inner_open, bus.outer_open, bus.pump_on, bus.fault};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic evac, input logic press, input logic isw,
                         input logic osw, input logic cdd);
        bus.evac_req  = evac;
        bus.press_req = press;
        bus.inner_sw  = isw;
        bus.outer_sw  = osw;
        bus.cd_done   = cdd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    // One clock: model follows the sampled inputs, DUT is compared #1 later.
    task automatic cycle(input string tag);
        @(posedge Clock);
        model_step();
        exp_q.push_back(model_vec());
        #1;
        check(tag, dut_vec(), exp_q.pop_front());
        check("interlock", bus.inner_open & bus.outer_open, 0);
        check("cd_twice", prev_cd & bus.countdown, 0);
        prev_cd = bus.countdown;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b0;
        prev_cd = 1'b0;
        idle();
        model_reset();

        // 1: reset and idle
        cycle("rst");
        cycle("rst");
        check("rst_outs", dut_vec(), 0);
        Reset = 1'b1;
        repeat (3) cycle("idle");
        check("idle_outs", dut_vec(), 0);

        // 2: evacuate
        bus.evac_req = 1;
        cycle("t2");
        check("t2_cd", bus.countdown, 1);
        check("t2_state", bus.state_o, 1);
        check("t2_pump", bus.pump_on, 1);
        bus.evac_req = 0;
        cycle("t2");
        check("t2_cd_once", bus.countdown, 0);
        repeat (3) cycle("t2");
        bus.cd_done = 1;
        cycle("t2");
        bus.cd_done = 0;
        check("t2_vac", bus.state_o, 2);
        check("t2_pump_off", bus.pump_on, 0);
        bus.outer_sw = 1;
        cycle("t2");
        check("t2_outer", bus.outer_open, 1);
        check("t2_inner", bus.inner_open, 0);

        // 3: press request blocked by open outer door
        bus.press_req = 1;
        repeat (3) cycle("t3");
        check("t3_hold", bus.state_o, 2);
        bus.outer_sw = 0;
        cycle("t3");
        check("t3_outer_closed", bus.outer_open, 0);
        check("t3_still_vac", bus.state_o, 2);
        cycle("t3");
        check("t3_fill", bus.state_o, 3);
        check("t3_cd", bus.countdown, 1);
        bus.press_req = 0;
        repeat (4) cycle("t3");
        bus.cd_done = 1;
        cycle("t3");
        bus.cd_done = 0;
        check("t3_press", bus.state_o, 0);
        bus.inner_sw = 1;
        cycle("t3");
        check("t3_inner", bus.inner_open, 1);
        bus.inner_sw = 0;
        cycle("t3");

        // 4: watchdog timeout in DRAIN
        bus.evac_req = 1;
        cycle("t4");
        bus.evac_req = 0;
        check("t4_cd", bus.countdown, 1);
        repeat (TIMEOUT - 1) cycle("t4");
        check("t4_not_yet", bus.fault, 0);
        cycle("t4");
        check("t4_fault", bus.fault, 1);
        check("t4_state", bus.state_o, 4);
        drive(1, 1, 0, 0, 1);
        repeat (3) cycle("t4");
        check("t4_sticky", bus.state_o, 4);
        idle();
        Reset = 1'b0;
        cycle("t4");
        Reset = 1'b1;
        check("t4_reset_state", bus.state_o, 0);
        check("t4_reset_fault", bus.fault, 0);

        // 5: cd_done on the final watchdog cycle wins
        bus.evac_req = 1;
        cycle("t5");
        bus.evac_req = 0;
        repeat (TIMEOUT - 1) cycle("t5");
        bus.cd_done = 1;
        cycle("t5");
        bus.cd_done = 0;
        check("t5_vac", bus.state_o, 2);
        check("t5_no_fault", bus.fault, 0);

        // 6: asynchronous reset mid-FILL
        bus.press_req = 1;
        cycle("t6");
        bus.press_req = 0;
        check("t6_fill", bus.state_o, 3);
        cycle("t6");
        #2;
        Reset = 1'b0;
        #1;
        check("t6_async", dut_vec(), 0);
        model_reset();
        prev_cd = 1'b0;
        cycle("t6");
        Reset = 1'b1;

        // random soak
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 9) == 0));
            Reset = (m_mode == 4 && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            cycle("rand");
        end
        Reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/airlock_ctrl.md
Name: airlock_ctrl

Overview:
Chamber controller for the two-door airlock. It sequences the evacuate and pressurize cycles and drives the one-cycle `countdown` start pulse into the downstream countdown timer. It consumes that timer's `cd_done` to decide when the pressure change is complete. It gates inner and outer door opening so that both doors are never open at once, and traps a missing-done condition as a fault.

Parameters:
- TIMEOUT, 32: max cycles to wait for `cd_done` after a countdown pulse before FAULT; legal range 2..255.
- CW, 8: width of the internal watchdog counter; must satisfy 2^CW > TIMEOUT.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- evac_req  input  1  level request to evacuate the chamber.
- press_req  input  1  level request to pressurize the chamber.
- inner_sw  input  1  operator wants inner door open (1 = open request).
- outer_sw  input  1  operator wants outer door open (1 = open request).
- cd_done  input  1  one-cycle pulse from the countdown timer: interval expired.
- countdown  output  1  one-cycle start pulse to the countdown timer.
- inner_open  output  1  inner door actuator.
- outer_open  output  1  outer door actuator.
- pump_on  output  1  pump active; high in DRAIN and FILL.
- fault  output  1  sticky watchdog fault.
- state_o  output  3  state code: PRESS=0, DRAIN=1, VAC=2, FILL=3, FAULT=4.

Behaviour:
- All outputs are registered.
- Reset asserted (Reset=0), asynchronously:
  - state = PRESS.
  - countdown, inner_open, outer_open, pump_on, fault = 0.
  - Watchdog = 0.
  - This holds regardless of the current state, including mid-DRAIN/FILL.
- PRESS:
  - inner_open <= inner_sw; outer_open <= 0.
  - If evac_req=1 and inner_sw=0 and inner_open=0: next state DRAIN, countdown <= 1 for exactly one cycle, watchdog <= 0.
  - evac_req with the inner door open or requested is ignored; stay in PRESS.
- DRAIN:
  - pump_on=1; both doors 0, forced closed the cycle DRAIN is entered.
  - Watchdog increments each cycle.
  - cd_done=1 -> VAC.
  - Else if watchdog = TIMEOUT-1 -> FAULT.
  - cd_done and timeout in the same cycle: cd_done wins.
  - evac_req and press_req are ignored.
- VAC:
  - outer_open <= outer_sw; inner_open <= 0.
  - If press_req=1 and outer_sw=0 and outer_open=0: next state FILL, one-cycle countdown pulse, watchdog <= 0.
- FILL: mirror of DRAIN; cd_done -> PRESS, timeout -> FAULT.
- FAULT:
  - fault=1, pump_on=0, both doors 0, countdown=0.
  - Exit only via Reset.
- Door interlock invariant: inner_open & outer_open is never 1 in any cycle.
- cd_done outside DRAIN/FILL is ignored and does not change state.
- countdown is never high two consecutive cycles. A new pulse is issued only on a PRESS->DRAIN or VAC->FILL transition.
- Latency:
  - Request accepted at edge N -> countdown=1 and pump_on=1 after edge N.
  - cd_done sampled at edge M -> new state and door enable after edge M; doors follow their switch from edge M+1.
- Watchdog saturates; it never wraps.

Test Plan:
1. Reset=0 for 2 cycles, then 1, all inputs 0 -> state_o=0, all outputs 0; PRESS held.
2. From PRESS: evac_req=1, inner_sw=0 -> countdown high exactly 1 cycle, state_o=1, pump_on=1. cd_done pulse 5 cycles later -> state_o=2, pump_on=0. Then outer_sw=1 -> outer_open=1 next cycle, inner_open stays 0.
3. From VAC with outer_sw=1: press_req=1 -> no transition, no countdown. Drop outer_sw -> outer_open=0, then FILL with a countdown pulse. cd_done -> state_o=0, inner_sw=1 -> inner_open=1.
4. DRAIN with no cd_done, TIMEOUT=32 -> fault=1 and state_o=4 exactly 32 cycles after the countdown pulse. Later cd_done and requests are ignored. Reset=0 -> back to state_o=0, fault=0.
5. cd_done asserted on the same cycle the watchdog hits TIMEOUT-1 -> next state VAC, fault stays 0.
6. Reset=0 asserted asynchronously between edges during FILL -> outputs clear immediately, before the next edge. Random inner_sw/outer_sw/request stimulus over 2000 cycles -> inner_open & outer_open never both 1, countdown never high 2 cycles in a row.
